// File: rtl/nonce_report_queue_pkg.sv
// Shared definitions for the nonce report queue: nonce width and transmit FSM encoding.
package nonce_report_queue_pkg;

  localparam int NONCE_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/nonce_report_queue_fifo.sv
// nonce_fifo: DEPTH-entry circular buffer of nonces with registered fill count.
module nonce_fifo
  import nonce_report_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic [NONCE_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic [NONCE_W-1:0] head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [CNT_W-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [NONCE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A push into a full buffer is only legal when the head leaves at the same edge.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/nonce_report_queue.sv
// Queues golden nonces and feeds them one at a time to serial_transmit.
// Optional NONCE_DEDUP_EN drops a hit equal to the last accepted nonce.
module nonce_report_queue
  import nonce_report_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hit_valid,
  input  logic [NONCE_W-1:0] hit_nonce,
  input  logic               tx_busy,
  output logic               tx_send,
  output logic [NONCE_W-1:0] tx_word,
  output logic [CNT_W-1:0]   fill_count,
  output logic               overflow,
  output tx_state_e          dbg_state
);

  tx_state_e          state_q, state_d;
  logic [NONCE_W-1:0] tx_word_q;
  logic               overflow_q;
  logic               pop, push, drop, hit_new, hit_dup;
  logic               fifo_full, fifo_empty;
  logic [NONCE_W-1:0] fifo_head;

  // Handshake: tx_send is a one-cycle strobe; serial_transmit raises tx_busy
  // some time later and drops it when done. A new word goes out only after
  // tx_busy has been seen high and then low again.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          pop     = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND:      state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (tx_busy)  state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!tx_busy) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

`ifdef NONCE_DEDUP_EN
  logic [NONCE_W-1:0] last_q;
  logic               last_vld_q;

  assign hit_dup = last_vld_q && (hit_nonce == last_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (push) begin
      last_q     <= hit_nonce;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign hit_dup = 1'b0;
`endif

  assign hit_new = hit_valid && !hit_dup;
  assign push    = hit_new && (!fifo_full || pop);
  assign drop    = hit_new && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_word_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop)  tx_word_q  <= fifo_head;
      if (drop) overflow_q <= 1'b1;
    end
  end

  nonce_fifo #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (hit_nonce),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fill_count)
  );

  assign tx_send   = (state_q == ST_SEND);
  assign tx_word   = tx_word_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: doc/nonce_report_queue.md
NONCE_REPORT_QUEUE -- requirements
Module: nonce_report_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 SHALL have parameter CNT_W, default 4, width of fill count; equals log2(DEPTH)+1.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port hit_valid  input  1  one-cycle pulse; hash core found a golden nonce.
REQ-006 SHALL have port hit_nonce  input  32  nonce qualified by hit_valid.
REQ-007 SHALL have port tx_busy  input  1  busy output of serial_transmit.
REQ-008 SHALL have port tx_send  output  1  send strobe to serial_transmit.
REQ-009 SHALL have port tx_word  output  32  word to serial_transmit; stable while tx_send high.
REQ-010 SHALL have port fill_count  output  CNT_W  entries currently queued.
REQ-011 SHALL have port overflow  output  1  sticky; a hit was dropped because the FIFO was full.

Function
REQ-012 SHALL buffer accepted nonces in a DEPTH-entry circular FIFO; read/write pointers wrap modulo DEPTH.
REQ-013 SHALL push hit_nonce at the edge where hit_valid=1 and the FIFO is not full, or is full with a pop at the same edge.
REQ-014 SHALL, on hit_valid=1 with FIFO full and no pop at that edge, drop the nonce, leave contents unchanged, and set overflow at that edge.
REQ-015 SHALL, on simultaneous push and pop, leave fill_count unchanged and preserve FIFO order.
REQ-016 SHALL run the transmit FSM with states IDLE, SEND, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE: if FIFO non-empty and tx_busy=0, pop the head into tx_word and go to SEND; otherwise stay.
REQ-018 SEND: tx_send=1 for exactly this one cycle; next state WAIT_BUSY.
REQ-019 WAIT_BUSY: tx_send=0; go to WAIT_DONE when tx_busy=1, else stay.
REQ-020 WAIT_DONE: go to IDLE when tx_busy=0, else stay.
REQ-021 tx_send SHALL be high only in SEND, so serial_transmit never captures a word twice.
REQ-022 Latency: a hit sampled at edge k into an empty FIFO with tx_busy=0 SHALL give tx_send=1 in the cycle after edge k+1.
REQ-023 tx_word SHALL hold its value from SEND until the next pop.
REQ-024 fill_count SHALL be registered and SHALL reflect pushes and pops of the preceding edge; range 0..DEPTH.

Reset
REQ-025 reset SHALL empty the FIFO, zero both pointers, and force IDLE.
REQ-026 After reset: tx_send=0, tx_word=0, fill_count=0, overflow=0.
REQ-027 reset SHALL take priority over a hit at the same edge; that hit is discarded.
REQ-028 Reset mid-transfer SHALL abandon the transfer; IDLE then waits for tx_busy=0 before the next send.
REQ-029 overflow SHALL clear only on reset.

Configuration
REQ-030 Macro NONCE_DEDUP_EN defined: SHALL hold the last accepted nonce plus a valid flag (cleared by reset), and SHALL silently discard a hit equal to it, without setting overflow.
REQ-031 NONCE_DEDUP_EN undefined: SHALL accept every hit, identical consecutive nonces included.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, SEND=1, WAIT_BUSY=2, WAIT_DONE=3) and the 32-bit nonce width constant.
REQ-033 SHALL split storage into one sub-module, nonce_fifo (push/pop/full/empty/count); the FSM and dedup logic stay in the top module.

Verification
REQ-034 Single hit 0xDEADBEEF into an empty queue, tx_busy model per serial_transmit -> one tx_send pulse two cycles after the hit, tx_word=0xDEADBEEF, fill_count returns to 0.
REQ-035 Burst of 10 hits 0x00000001..0x0000000A on consecutive cycles with DEPTH=8 and tx_busy held high -> fill_count=8, overflow=1, later drains 1..8 in order, 9 and 10 never sent.
REQ-036 FIFO full and tx_busy falling at the pop edge while hit 0x55AA55AA arrives -> push accepted, fill_count stays 8, overflow stays 0.
REQ-037 reset asserted in WAIT_DONE with 3 entries queued and tx_busy=1 -> fill_count=0, tx_send=0, no send until tx_busy=0 and a new hit arrives.
REQ-038 NONCE_DEDUP_EN defined, hits 0x12345678, 0x12345678, 0x9ABCDEF0 -> exactly two words sent, in that order; overflow=0.
REQ-039 tx_busy stuck low after a send (no rise) -> FSM stays in WAIT_BUSY, no second tx_send pulse.
